// File: rtl/hrange_gen.sv
// hrange_gen: ready/valid generator for range(base, limit, step), LANES values per beat.
// Lane k of a beat carries cursor + k*step. A mask marks the lanes that are still in range.
// The beat whose following value falls out of range carries _last.
// Optional build macro HRANGE_GEN_OVF_CHECK_EN: lane values are compared unwrapped in
// wider arithmetic, so a value that overflows WIDTH ends the sequence instead of wrapping.
module hrange_gen #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned LANES = 1
) (
  input  logic                    _clock,
  input  logic                    _reset_n,
  input  logic                    _start,
  input  logic signed [WIDTH-1:0] base,
  input  logic signed [WIDTH-1:0] limit,
  input  logic signed [WIDTH-1:0] step,
  input  logic                    _ready,
  output logic                    _valid,
  output logic [LANES*WIDTH-1:0]  _out0,
  output logic [LANES-1:0]        _mask,
  output logic                    _last,
  output logic                    _done
);

  // Wide enough to hold cursor + LANES*step without loss for any LANES up to 8.
  localparam int unsigned EW = WIDTH + 1 + $clog2(LANES);

  typedef enum logic [0:0] {StDone, StRun} state_e;

  state_e                  state_q, state_d;
  logic signed [WIDTH-1:0] cur_q, cur_d;
  logic signed [WIDTH-1:0] lim_q, lim_d;
  logic signed [WIDTH-1:0] step_q, step_d;
  logic signed [WIDTH-1:0] stepn_q, stepn_d;

  logic signed [EW-1:0]    lim_x;
  logic signed [EW-1:0]    lv;
  logic                    dir_pos, dir_neg;
  logic                    run;
  logic [LANES:0]          m;
  logic [LANES*WIDTH-1:0]  lanes_v;
  logic                    start_pos, start_neg, start_ok;

  // Value of lane k, sign-extended to EW bits (wrapped to WIDTH unless overflow checking).
  function automatic logic signed [EW-1:0] lane_val(input logic signed [WIDTH-1:0] cur,
                                                    input logic signed [WIDTH-1:0] stp,
                                                    input int unsigned k);
`ifdef HRANGE_GEN_OVF_CHECK_EN
    logic signed [EW-1:0] cx;
    logic signed [EW-1:0] sx;
    cx = {{(EW-WIDTH){cur[WIDTH-1]}}, cur};
    sx = {{(EW-WIDTH){stp[WIDTH-1]}}, stp};
    return cx + sx * $signed(EW'(k));
`else
    logic signed [WIDTH-1:0] w;
    w = cur + stp * $signed(WIDTH'(k));
    return {{(EW-WIDTH){w[WIDTH-1]}}, w};
`endif
  endfunction

  function automatic logic in_range(input logic signed [EW-1:0] v,
                                    input logic signed [EW-1:0] lx,
                                    input logic pos,
                                    input logic neg);
    return pos ? (v < lx) : (neg && (v > lx));
  endfunction

  // Lane values and the cumulative in-range mask; m[LANES] is the value after the beat.
  always_comb begin
    lim_x   = {{(EW-WIDTH){lim_q[WIDTH-1]}}, lim_q};
    dir_pos = !step_q[WIDTH-1] && (|step_q);
    dir_neg = step_q[WIDTH-1];
    run     = 1'b1;
    m       = '0;
    lanes_v = '0;
    lv      = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      lv   = lane_val(cur_q, step_q, k);
      run  = run & in_range(lv, lim_x, dir_pos, dir_neg);
      m[k] = run;
      lanes_v[k*WIDTH +: WIDTH] = run ? lv[WIDTH-1:0] : '0;
    end
    lv       = lane_val(cur_q, step_q, LANES);
    m[LANES] = run & in_range(lv, lim_x, dir_pos, dir_neg);
  end

  // Start-time emptiness check on the raw inputs; step==0 counts as empty.
  always_comb begin
    start_pos = !step[WIDTH-1] && (|step);
    start_neg = step[WIDTH-1];
    start_ok  = start_pos ? (base < limit) : (start_neg && (base > limit));
  end

  // Next state: _start wins over any handshake; accepting the _last beat finishes.
  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    lim_d   = lim_q;
    step_d  = step_q;
    stepn_d = stepn_q;
    if (_start) begin
      cur_d   = base;
      lim_d   = limit;
      step_d  = step;
      stepn_d = step * $signed(WIDTH'(LANES));
      state_d = start_ok ? StRun : StDone;
    end else begin
      unique case (state_q)
        StRun: begin
          if (_ready) begin
            if (!m[LANES]) state_d = StDone;
            else           cur_d   = cur_q + stepn_q;
          end
        end
        default: ;
      endcase
    end
  end

  // State and sequence registers.
  always_ff @(posedge _clock or negedge _reset_n) begin
    if (!_reset_n) begin
      state_q <= StDone;
      cur_q   <= '0;
      lim_q   <= '0;
      step_q  <= '0;
      stepn_q <= '0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      lim_q   <= lim_d;
      step_q  <= step_d;
      stepn_q <= stepn_d;
    end
  end

  // Beat outputs are zero whenever no beat is presented.
  always_comb begin
    _valid = (state_q == StRun);
    _done  = (state_q == StDone);
    _out0  = _valid ? lanes_v : '0;
    _mask  = _valid ? m[LANES-1:0] : '0;
    _last  = _valid && !m[LANES];
  end

endmodule
